// File: rtl/aes128_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes128_iter_ctrl
// Brief    : Iterative AES-128 encryption controller, one round per clock,
//            with an on-the-fly key schedule.
// Revision : 1.0 - initial release
// ============================================================================
module aes128_iter_ctrl #(
    parameter int WIDTH = 128
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] key_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic [3:0]       round_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_t;

    localparam logic [3:0] c_LAST_ROUND = 4'd10;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    fsm_t             r_fsm;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_rkey;
    logic [WIDTH-1:0] r_data_out;
    logic [3:0]       r_rnd;
    logic [7:0]       r_rcon;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_sb;
    logic [WIDTH-1:0] w_sr;
    logic [WIDTH-1:0] w_mc;
    logic [WIDTH-1:0] w_next_key;
    logic [31:0]      w_rot;
    logic [31:0]      w_sub;
    logic [31:0]      w_t;

    // Byte i of the block lives at bits [127-8i -: 8]; row = i%4, col = i/4
    generate
        for (genvar i = 0; i < 16; i++) begin : g_sbox
            assign w_sb[127-8*i -: 8] = sbox(r_state[127-8*i -: 8]);
        end
    endgenerate

    always_comb begin
        w_sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[127-8*(r+4*c) -: 8] = w_sb[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
    end

    generate
        for (genvar c = 0; c < 4; c++) begin : g_mix
            assign w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
        end
    endgenerate

    assign w_rot = {r_rkey[23:0], r_rkey[31:24]};

    generate
        for (genvar b = 0; b < 4; b++) begin : g_key_sbox
            assign w_sub[31-8*b -: 8] = sbox(w_rot[31-8*b -: 8]);
        end
    endgenerate

    assign w_t = w_sub ^ {r_rcon, 24'h000000};

    always_comb begin
        w_next_key[127:96] = r_rkey[127:96] ^ w_t;
        w_next_key[95:64]  = r_rkey[95:64]  ^ w_next_key[127:96];
        w_next_key[63:32]  = r_rkey[63:32]  ^ w_next_key[95:64];
        w_next_key[31:0]   = r_rkey[31:0]   ^ w_next_key[63:32];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_fsm      <= S_IDLE;
            r_state    <= '0;
            r_rkey     <= '0;
            r_data_out <= '0;
            r_rnd      <= 4'd0;
            r_rcon     <= 8'h00;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start_i && r_ready) begin
                        r_state <= data_i ^ key_i;
                        r_rkey  <= key_i;
                        r_rnd   <= 4'd1;
                        r_rcon  <= 8'h01;
                        r_fsm   <= S_ROUND;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ROUND: begin
                    r_rkey <= w_next_key;
                    r_rcon <= xtime(r_rcon);
                    if (r_rnd == c_LAST_ROUND) begin
                        // final round skips MixColumn
                        r_data_out <= w_sr ^ w_next_key;
                        r_rnd      <= 4'd0;
                        r_fsm      <= S_DONE;
                        r_done     <= 1'b1;
                    end else begin
                        r_state <= w_mc ^ w_next_key;
                        r_rnd   <= r_rnd + 4'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_fsm   <= S_IDLE;
                end
                default: begin
                    r_fsm   <= S_IDLE;
                    r_rnd   <= 4'd0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign busy_o  = r_busy;
    assign round_o = r_rnd;
    assign done_o  = r_done;
    assign data_o  = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_aes128_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes128_iter_ctrl
// Brief    : Directed-vector bench for aes128_iter_ctrl (FIPS-197 vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes128_iter_ctrl;

    localparam logic [127:0] c_PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] c_RK10_Z = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         start_i;
    logic [127:0] data_i;
    logic [127:0] key_i;
    logic         ready_o;
    logic         busy_o;
    logic [3:0]   round_o;
    logic         done_o;
    logic [127:0] data_o;

    int n_checks = 0;
    int n_errors = 0;

    aes128_iter_ctrl #(.WIDTH(128)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .start_i (start_i),
        .data_i  (data_i),
        .key_i   (key_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .round_o (round_o),
        .done_o  (done_o),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " ready"}, ready_o, 1);
        check({tag, " busy"},  busy_o, 0);
        check({tag, " round"}, round_o, 0);
        check({tag, " done"},  done_o, 0);
    endtask

    // One start pulse, then walk the rounds until done_o or a cycle budget
    task automatic run_block(input string tag, input logic [127:0] d, input logic [127:0] k,
                             input logic [127:0] exp, input bit scramble);
        int cnt;
        bit seen;
        @(negedge clk_i);
        start_i = 1'b1;
        data_i  = d;
        key_i   = k;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        cnt  = 0;
        seen = 0;
        while (!seen && cnt < 20) begin
            @(negedge clk_i);
            cnt++;
            if (scramble) begin
                data_i = rand128();
                key_i  = rand128();
            end
            if (done_o) seen = 1;
            else check($sformatf("%s round@%0d", tag, cnt), round_o, (cnt <= 10) ? cnt : 0);
        end
        check({tag, " latency"}, cnt, 11);
        check({tag, " ciphertext"}, data_o, exp);
        check({tag, " busy@done"}, busy_o, 1);
        check({tag, " round@done"}, round_o, 0);
        @(negedge clk_i);
        check_idle({tag, " after"});
        check({tag, " hold"}, data_o, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  cnt;
        int  dones;
        bit  seen;

        rst_n_i = 1'b0;
        start_i = 1'b0;
        data_i  = '0;
        key_i   = '0;
        repeat (3) @(negedge clk_i);
        check_idle("reset");
        check("reset data", data_o, 0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check_idle("post reset");

        run_block("appB", c_PT_B, c_KEY_B, c_CT_B, 0);
        run_block("appC1", c_PT_C, c_KEY_C, c_CT_C, 0);

        // start held high while busy must not queue a block
        @(negedge clk_i);
        start_i = 1'b1;
        data_i  = c_PT_B;
        key_i   = c_KEY_B;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        cnt  = 0;
        seen = 0;
        while (!seen && cnt < 20) begin
            @(negedge clk_i);
            cnt++;
            if (cnt == 3) begin
                start_i = 1'b1;
                data_i  = c_PT_C;
                key_i   = c_KEY_C;
            end
            if (done_o) seen = 1;
        end
        check("busy first latency", cnt, 11);
        check("busy first ciphertext", data_o, c_CT_B);
        @(negedge clk_i);
        check("busy ready after E11", ready_o, 1);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        @(negedge clk_i);
        check("busy second accepted E12", round_o, 1);
        check("busy second busy", busy_o, 1);
        cnt  = 1;
        seen = 0;
        while (!seen && cnt < 20) begin
            @(negedge clk_i);
            cnt++;
            if (done_o) seen = 1;
        end
        check("busy second latency", cnt, 11);
        check("busy second ciphertext", data_o, c_CT_C);

        run_block("stableC1", c_PT_C, c_KEY_C, c_CT_C, 1);
        run_block("stableB", c_PT_B, c_KEY_B, c_CT_B, 1);

        // asynchronous reset in the middle of round 5
        @(negedge clk_i);
        start_i = 1'b1;
        data_i  = c_PT_B;
        key_i   = c_KEY_B;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        cnt = 0;
        while (round_o != 4'd5 && cnt < 20) begin
            @(negedge clk_i);
            cnt++;
        end
        check("abort reached round5", round_o, 5);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_idle("abort");
        check("abort data", data_o, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        dones = 0;
        repeat (15) begin
            @(negedge clk_i);
            if (done_o) dones++;
        end
        check("abort no done", dones, 0);
        run_block("after abort appB", c_PT_B, c_KEY_B, c_CT_B, 0);

        run_block("zero", 128'h0, 128'h0, c_CT_Z, 0);
        check("zero round10 key", dut.r_rkey, c_RK10_Z);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
